// File: rtl/fifo_w1r1_pkg.sv
// rtl/fifo_w1r1_pkg.sv - shared width helpers for the fifo_w1r1 slice
package fifo_w1r1_pkg;

   // Pointer width: enough bits to address every slot; never collapses to zero bits.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Count width: must be able to hold the full value DEPTH, hence depth+1.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_w1r1_storage.sv
// rtl/fifo_w1r1_storage.sv - FIFO entry array, resettable flops or non-reset memory style
module fifo_w1r1_storage
   import fifo_w1r1_pkg::*;
#(
   parameter int WIDTH         = 8,
   parameter int DEPTH         = 4,
   parameter int FLOPS_NOT_MEM = 0,
   parameter int PTR_W         = 2
)
(
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_we,
   input  logic [PTR_W-1:0]       i_waddr,
   input  logic [WIDTH-1:0]       i_wdata,
   input  logic [PTR_W-1:0]       i_raddr,
   output logic [WIDTH-1:0]       o_rdata,
   output logic [DEPTH*WIDTH-1:0] o_entries
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             we_eff;

   // Reset always wins over a write in the same cycle, in both storage styles.
   assign we_eff = i_we & ~i_rst;

   if (FLOPS_NOT_MEM != 0) begin : g_flops
      logic [WIDTH-1:0] mem_d [DEPTH];

      // Next array value: only the addressed slot changes on a write.
      always_comb begin
         mem_d = mem_q;
         if (we_eff) begin
            mem_d[i_waddr] = i_wdata;
         end
      end

      // Resettable entry registers.
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
               mem_q[k] <= '0;
            end
         end else begin
            mem_q <= mem_d;
         end
      end
   end else begin : g_mem
      // Memory-style array: single addressed write port, contents survive reset.
      always_ff @(posedge i_clk) begin
         if (we_eff) begin
            mem_q[i_waddr] <= i_wdata;
         end
      end
   end

   // First-word-fall-through read is a plain combinational mux.
   assign o_rdata = mem_q[i_raddr];

   for (genvar k = 0; k < DEPTH; k++) begin : g_flat
      assign o_entries[k*WIDTH +: WIDTH] = mem_q[k];
   end

endmodule

// File: rtl/fifo_w1r1.sv
// rtl/fifo_w1r1.sv - one-write one-read FWFT FIFO; assertions enabled by FIFO_W1R1_ASSERT_EN
module fifo_w1r1
   import fifo_w1r1_pkg::*;
#(
   parameter int WIDTH              = 8,
   parameter int DEPTH              = 4,
   parameter int FLOPS_NOT_MEM      = 0,
   parameter int FORCEKEEP_NENTRIES = 0
)
(
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_cg,
   input  logic                          i_flush,
   input  logic [WIDTH-1:0]              i_data,
   input  logic                          i_valid,
   output logic                          o_ready,
   output logic [WIDTH-1:0]              o_data,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic                          o_pushed,
   output logic                          o_popped,
   output logic [ptr_width(DEPTH)-1:0]   o_wptr,
   output logic [ptr_width(DEPTH)-1:0]   o_rptr,
   output logic [DEPTH-1:0]              o_validEntries,
   output logic [cnt_width(DEPTH)-1:0]   o_nEntries,
   output logic [DEPTH*WIDTH-1:0]        o_entries
);

   localparam int PTR_W = ptr_width(DEPTH);
   localparam int CNT_W = cnt_width(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [CNT_W-1:0] n_entries;
   logic             push, pop;

   // Handshake flags come only from registered state, so a pop never frees room
   // for a push in the same cycle.
   assign o_ready = (n_entries != FULL_CNT);
   assign o_valid = (n_entries != '0);
   assign push    = i_cg & i_valid & o_ready;
   assign pop     = i_cg & o_valid & i_ready;

   // Pointer and valid-flag next state; flush overrides any handshake.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      valid_d = valid_q;
      if (i_cg) begin
         if (i_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            valid_d = '0;
         end else begin
            if (pop) begin
               valid_d[rptr_q] = 1'b0;
               rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
            end
            if (push) begin
               valid_d[wptr_q] = 1'b1;
               wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
            end
         end
      end
   end

   // Control registers with synchronous reset taking priority over everything.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         valid_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         valid_q <= valid_d;
      end
   end

   if (FORCEKEEP_NENTRIES != 0) begin : g_count
      logic [CNT_W-1:0] count_q, count_d;

      // Explicit occupancy counter; simultaneous push and pop leaves it unchanged.
      always_comb begin
         count_d = count_q;
         if (i_cg) begin
            if (i_flush) begin
               count_d = '0;
            end else if (push && !pop) begin
               count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
               count_d = count_q - CNT_W'(1);
            end
         end
      end

      // Counter register.
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            count_q <= '0;
         end else begin
            count_q <= count_d;
         end
      end

      assign n_entries = count_q;
   end else begin : g_derived
      assign n_entries = CNT_W'($countones(valid_q));
   end

   fifo_w1r1_storage #(
      .WIDTH         (WIDTH),
      .DEPTH         (DEPTH),
      .FLOPS_NOT_MEM (FLOPS_NOT_MEM),
      .PTR_W         (PTR_W)
   ) u_storage (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_we      (push & ~i_flush),
      .i_waddr   (wptr_q),
      .i_wdata   (i_data),
      .i_raddr   (rptr_q),
      .o_rdata   (o_data),
      .o_entries (o_entries)
   );

   assign o_pushed       = push;
   assign o_popped       = pop;
   assign o_wptr         = wptr_q;
   assign o_rptr         = rptr_q;
   assign o_validEntries = valid_q;
   assign o_nEntries     = n_entries;

`ifdef FIFO_W1R1_ASSERT_EN
   a_no_push_full: assert property (@(posedge i_clk) disable iff (i_rst)
      !(push && (n_entries == FULL_CNT)));
   a_no_pop_empty: assert property (@(posedge i_clk) disable iff (i_rst)
      !(pop && (n_entries == '0)));
   a_count_matches_flags: assert property (@(posedge i_clk) disable iff (i_rst)
      (n_entries == CNT_W'($countones(valid_q))));
   a_count_bounded: assert property (@(posedge i_clk) disable iff (i_rst)
      (n_entries <= FULL_CNT));
`else
   // checks compiled out; datapath and control unchanged
`endif

endmodule

// File: tb/tb_fifo_w1r1.sv
// tb/tb_fifo_w1r1.sv - directed and random self-checking bench for fifo_w1r1
module tb_fifo_w1r1;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, cg, flush, in_valid, out_ready;
   logic [WIDTH-1:0] in_data;

   logic             rdy_a, vld_a, psh_a, pop_a;
   logic [7:0]       dat_a;
   logic [1:0]       wp_a, rp_a;
   logic [3:0]       ve_a;
   logic [2:0]       n_a;
   logic [31:0]      ent_a;

   logic             rdy_b, vld_b, psh_b, pop_b;
   logic [7:0]       dat_b;
   logic [1:0]       wp_b, rp_b;
   logic [3:0]       ve_b;
   logic [2:0]       n_b;
   logic [31:0]      ent_b;

   fifo_w1r1 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FLOPS_NOT_MEM(0), .FORCEKEEP_NENTRIES(0)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_flush(flush),
      .i_data(in_data), .i_valid(in_valid), .o_ready(rdy_a),
      .o_data(dat_a), .o_valid(vld_a), .i_ready(out_ready),
      .o_pushed(psh_a), .o_popped(pop_a), .o_wptr(wp_a), .o_rptr(rp_a),
      .o_validEntries(ve_a), .o_nEntries(n_a), .o_entries(ent_a)
   );

   fifo_w1r1 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FLOPS_NOT_MEM(1), .FORCEKEEP_NENTRIES(1)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_flush(flush),
      .i_data(in_data), .i_valid(in_valid), .o_ready(rdy_b),
      .o_data(dat_b), .o_valid(vld_b), .i_ready(out_ready),
      .o_pushed(psh_b), .o_popped(pop_b), .o_wptr(wp_b), .o_rptr(rp_b),
      .o_validEntries(ve_b), .o_nEntries(n_b), .o_entries(ent_b)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_state(input string tag, input int n, input int w, input int r);
      check({tag, "_n_a"}, 32'(n_a), n);
      check({tag, "_n_b"}, 32'(n_b), n);
      check({tag, "_wptr_a"}, 32'(wp_a), w);
      check({tag, "_wptr_b"}, 32'(wp_b), w);
      check({tag, "_rptr_a"}, 32'(rp_a), r);
      check({tag, "_rptr_b"}, 32'(rp_b), r);
   endtask

   task automatic chk_flags(input string tag, input logic v, input logic rd);
      check({tag, "_valid_a"}, 32'(vld_a), 32'(v));
      check({tag, "_valid_b"}, 32'(vld_b), 32'(v));
      check({tag, "_ready_a"}, 32'(rdy_a), 32'(rd));
      check({tag, "_ready_b"}, 32'(rdy_b), 32'(rd));
   endtask

   task automatic chk_hs(input string tag, input logic p, input logic q);
      check({tag, "_pushed_a"}, 32'(psh_a), 32'(p));
      check({tag, "_pushed_b"}, 32'(psh_b), 32'(p));
      check({tag, "_popped_a"}, 32'(pop_a), 32'(q));
      check({tag, "_popped_b"}, 32'(pop_b), 32'(q));
   endtask

   task automatic chk_data(input string tag, input logic [7:0] d);
      check({tag, "_data_a"}, 32'(dat_a), 32'(d));
      check({tag, "_data_b"}, 32'(dat_b), 32'(d));
   endtask

   task automatic chk_ve(input string tag, input logic [3:0] v);
      check({tag, "_ve_a"}, 32'(ve_a), 32'(v));
      check({tag, "_ve_b"}, 32'(ve_b), 32'(v));
   endtask

   logic [7:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [7:0] model_q [$];
   logic       exp_push, exp_pop;

   initial begin
      rst = 1'b1; cg = 1'b0; flush = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      tick();
      tick();
      rst = 1'b0;
      settle();
      chk_state("reset", 0, 0, 0);
      chk_flags("reset", 1'b0, 1'b1);
      chk_ve("reset", 4'h0);
      check("reset_entries_b", ent_b, 32'h0);

      // fill to DEPTH
      cg = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = fill[i];
         settle();
         chk_hs($sformatf("fill%0d", i), 1'b1, 1'b0);
         tick();
      end
      in_valid = 1'b0;
      settle();
      chk_state("full", 4, 0, 0);
      chk_flags("full", 1'b1, 1'b0);
      chk_ve("full", 4'hF);
      check("full_entries_a", ent_a, 32'h44332211);
      check("full_entries_b", ent_b, 32'h44332211);

      // pop while full: push refused in the same cycle
      in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
      settle();
      chk_hs("full_pop", 1'b0, 1'b1);
      chk_data("drain0", 8'h11);
      tick();
      in_valid = 1'b0;
      settle();
      chk_state("after_full_pop", 3, 0, 1);
      chk_flags("after_full_pop", 1'b1, 1'b1);
      for (int i = 1; i < 4; i++) begin
         chk_data($sformatf("drain%0d", i), fill[i]);
         tick();
      end
      out_ready = 1'b0;
      settle();
      chk_state("drained", 0, 0, 0);
      chk_flags("drained", 1'b0, 1'b1);

      // simultaneous push and pop at two entries
      in_valid = 1'b1; in_data = 8'hA1; tick();
      in_data = 8'hA2; tick();
      in_data = 8'h55; out_ready = 1'b1;
      settle();
      chk_data("simul", 8'hA1);
      chk_hs("simul", 1'b1, 1'b1);
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      settle();
      chk_state("simul_after", 2, 3, 1);
      chk_data("simul_after", 8'hA2);

      // clock gate off: nothing moves
      cg = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = 8'hEE;
      settle();
      chk_hs("cg_off", 1'b0, 1'b0);
      tick();
      tick();
      chk_state("cg_off", 2, 3, 1);
      chk_data("cg_off", 8'hA2);
      chk_ve("cg_off", 4'b0110);

      // drain, push one, then reset mid-operation with push/pop/flush active
      cg = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk_data("pop_55", 8'h55);
      tick();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
      tick();
      chk_state("pre_rst", 1, 0, 3);
      rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
      tick();
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      settle();
      chk_state("mid_rst", 0, 0, 0);
      chk_flags("mid_rst", 1'b0, 1'b1);

      // six push/pop pairs wrap both pointers to 2
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_data = 8'(8'h60 + i);
         tick();
         in_valid = 1'b0; out_ready = 1'b1;
         settle();
         chk_data($sformatf("wrap%0d", i), 8'(8'h60 + i));
         tick();
         out_ready = 1'b0;
      end
      settle();
      chk_state("wrap", 0, 2, 2);

      // three entries straddling the wrap, then flush
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'(8'h70 + i);
         tick();
      end
      in_valid = 1'b0;
      settle();
      chk_state("pre_flush", 3, 1, 2);
      chk_ve("pre_flush", 4'b1101);
      chk_data("pre_flush", 8'h70);
      flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 8'hF0;
      settle();
      chk_hs("flush_raw", 1'b1, 1'b1);
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      settle();
      chk_state("flushed", 0, 0, 0);
      chk_flags("flushed", 1'b0, 1'b1);
      chk_ve("flushed", 4'h0);

      // random traffic against a queue model
      for (int c = 0; c < 10000; c++) begin
         cg        = ($urandom_range(0, 3) != 0);
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         settle();
         exp_push = cg && in_valid && (model_q.size() != DEPTH);
         exp_pop  = cg && out_ready && (model_q.size() != 0);
         chk_hs("rnd", exp_push, exp_pop);
         check("rnd_n_a", 32'(n_a), model_q.size());
         check("rnd_n_b", 32'(n_b), model_q.size());
         if (model_q.size() != 0) begin
            chk_data("rnd", model_q[0]);
         end
         tick();
         if (exp_pop) begin
            void'(model_q.pop_front());
         end
         if (exp_push) begin
            model_q.push_back(in_data);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_w1r1.md
FIFO_W1R1 -- requirements
Module: fifo_w1r1

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per entry (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of entries (>=2, any integer, not restricted to powers of two).
REQ-003 SHALL have parameter FLOPS_NOT_MEM, default 0: 1 = resettable flop storage, 0 = non-reset memory-style array.
REQ-004 SHALL have parameter FORCEKEEP_NENTRIES, default 0: 1 = keep an explicit occupancy counter register, 0 = derive occupancy from o_validEntries; outputs are identical either way.
REQ-005 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst, input, 1, reset: synchronous, active-high.
REQ-007 SHALL have port i_cg, input, 1, clock-gate enable; state updates only when 1.
REQ-008 SHALL have port i_flush, input, 1, synchronous empty request.
REQ-009 SHALL have ports i_data (input, WIDTH), i_valid (input, 1) and o_ready (output, 1): the write handshake.
REQ-010 SHALL have ports o_data (output, WIDTH), o_valid (output, 1) and i_ready (input, 1): the read handshake.
REQ-011 SHALL have ports o_pushed and o_popped, output, 1 each, handshake-completion strobes for the current cycle.
REQ-012 SHALL have ports o_wptr and o_rptr, output, $clog2(DEPTH) each, the write and read pointers.
REQ-013 SHALL have port o_validEntries, output, DEPTH, per-entry occupied flags indexed by storage slot.
REQ-014 SHALL have port o_nEntries, output, $clog2(DEPTH+1), the occupancy count.
REQ-015 SHALL have port o_entries, output, DEPTH*WIDTH, the flattened storage; slot k occupies bits [k*WIDTH +: WIDTH].

Function
REQ-016 SHALL drive o_ready = (o_nEntries != DEPTH) and o_valid = (o_nEntries != 0), both combinational from state.
REQ-017 SHALL drive o_pushed = i_cg & i_valid & o_ready and o_popped = i_cg & o_valid & i_ready.
REQ-018 SHALL have first-word-fall-through reads: o_data = entry[o_rptr] combinationally, so data is visible the cycle after it is pushed.
REQ-019 SHALL on a push write i_data to slot o_wptr, set that slot's valid flag and advance o_wptr; on a pop clear slot o_rptr's valid flag and advance o_rptr.
REQ-020 SHALL wrap pointers from DEPTH-1 to 0.
REQ-021 SHALL on a simultaneous push and pop (only possible when not full and not empty) keep o_nEntries unchanged; otherwise push adds 1 and pop subtracts 1.
REQ-022 SHALL, when full, not push even if a pop occurs in the same cycle; o_ready stays 0 until the following cycle.
REQ-023 SHALL make no state change while i_cg=0; o_pushed and o_popped SHALL be 0.
REQ-024 SHALL, when i_flush=1 and i_cg=1, set pointers, count and valid flags to 0 next cycle, with priority over push/pop; o_pushed/o_popped still report the raw handshake that cycle.
REQ-025 SHALL preserve element order exactly: the pop sequence equals the push sequence, with no loss or duplication.

Reset
REQ-026 SHALL, with i_rst=1 at a rising edge (regardless of i_cg), zero o_wptr, o_rptr, o_nEntries and o_validEntries, giving o_valid=0 and o_ready=1.
REQ-027 SHALL zero storage on reset when FLOPS_NOT_MEM=1; when 0, storage is not reset and o_data is don't-care while o_valid=0.
REQ-028 SHALL let reset asserted mid-operation override any push, pop or flush in that cycle.

Configuration
REQ-029 SHALL, with macro FIFO_W1R1_ASSERT_EN defined, include assertions: no push while full, no pop while empty, o_nEntries equals popcount(o_validEntries), and o_nEntries <= DEPTH.
REQ-030 SHALL, without FIFO_W1R1_ASSERT_EN, contain no assertion logic, with identical functional behaviour.

Structure
REQ-031 SHALL place the pointer-width and count-width helper functions (clog2-based) in shared package fifo_w1r1_pkg.
REQ-032 SHALL use one sub-module, fifo_w1r1_storage, holding the entry array and selected by FLOPS_NOT_MEM.

Verification
REQ-033 SHALL cover reset: after i_rst=1, o_valid=0, o_ready=1, o_nEntries=0, o_wptr=o_rptr=0.
REQ-034 SHALL cover fill and drain: with DEPTH=4, push 0x11,0x22,0x33,0x44 -> o_ready=0 and o_nEntries=4; then pop all -> data 11,22,33,44 in order and o_valid=0.
REQ-035 SHALL cover simultaneous push and pop: at nEntries=2, push 0x55 and pop in one cycle -> nEntries stays 2 and the oldest entry is popped.
REQ-036 SHALL cover the clock gate: i_cg=0 with i_valid=i_ready=1 -> o_pushed=o_popped=0 and all state unchanged.
REQ-037 SHALL cover flush and wrap: push 6 and pop 6 at DEPTH=4 -> pointers wrap to 2; then flush at nEntries=3 -> nEntries=0 and pointers 0 next cycle.
REQ-038 SHALL cover random traffic: 10k cycles of random i_valid/i_ready/i_cg -> pop log equals push log.
